game_timer_gen: RTL and testbench
=================================

# game_timer_gen

Parametrised BCD game timer for the Snake 7-segment display path. It counts up (stopwatch) or down (countdown) in fixed ticks, and supports pause/resume, preset load and an expiry pulse. It drives the packed BCD digits, decimal-point, sign and enable inputs of the segment driver, and reports `expired` to game control.

## Interface
- `TICK_CNT_MAX`, default 2_499_999: prescaler terminal value; tick period = TICK_CNT_MAX+1 clocks (100 ms at 25 MHz).
- `DIGITS`, default 4: number of BCD digits, range 2..6.
- `FRAC_DIGITS`, default 1: digits right of the decimal point, range 0..DIGITS-1.
- `sys_clk` in 1: system clock.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `clear_signal` in 1: synchronous clear, level.
- `start_signal` in 1: start from IDLE, or resume from PAUSE.
- `pause_signal` in 1: pause from RUN.
- `mode` in 1: 0 = count up, 1 = count down; sampled only on start from IDLE.
- `load_en` in 1: load `load_val` into the count.
- `load_val` in DIGITS*4: BCD preset; digit 0 is least significant.
- `data` out DIGITS*4: packed BCD count.
- `point` out DIGITS: decimal point, active high; bit i belongs to digit i.
- `sign` out 1: constant 0.
- `seg_en` out 1: display enable.
- `running` out 1: high while state = RUN.
- `expired` out 1: one-cycle pulse at the terminal count.

## Operation
- States:
  - IDLE (reset state)
  - RUN
  - PAUSE
  - DONE
- Input priority each edge: clear > load > start/pause.
- Clear (any state): `data`←0, prescaler←0, state←IDLE, `expired`←0.
- Load: accepted in IDLE, PAUSE and DONE; ignored in RUN.
  - `data`←`load_val`, with each digit >9 clamped to 9.
  - prescaler←0, state←IDLE.
- IDLE + start:
  - latch `mode` into `mode_q`; prescaler←0; state←RUN.
  - Exception: if `mode`=1 and `data`=0, go directly to DONE and pulse `expired`.
- RUN:
  - prescaler increments every clock.
  - At prescaler = TICK_CNT_MAX: prescaler←0 and apply one tick.
    - Up: BCD increment with decimal carry across all digits.
    - Down: BCD decrement with borrow.
  - `pause_signal` → PAUSE with the prescaler held; `start_signal` is ignored.
- PAUSE: `data` and prescaler frozen; start → RUN, continuing from the held prescaler value; pause is ignored.
- Terminal count:
  - Up: the tick that produces all-9s enters DONE.
  - Down: the tick that produces 0 enters DONE.
  - Neither direction wraps.
- DONE: `data` held; start and pause ignored; only clear or load leave DONE.
- IDLE + pause: ignored. IDLE + start + pause together: start wins.
- Changes on `mode` outside IDLE-start are ignored; resume uses `mode_q`.
- `point`: bit FRAC_DIGITS = 1 when FRAC_DIGITS>0, else all 0. Example: DIGITS=4, FRAC_DIGITS=1 gives 4'b0010.

## Timing
- Reset values:
  - `data`=0, `seg_en`=0, `running`=0, `expired`=0, `sign`=0.
  - `point` is constant.
  - prescaler=0, state IDLE, `mode_q`=0.
- `seg_en`: 1 from the first edge after reset release, then stays 1.
- All outputs are registered except `point` and `sign`, which are constants.
- First tick: `data` changes on the (TICK_CNT_MAX+1)th edge after the edge that accepted start.
- Resume from held prescaler value p: tick occurs (TICK_CNT_MAX−p+1) edges after the resume edge.
- `expired`:
  - high for exactly the one cycle following the edge that enters DONE;
  - `running` falls on that same edge.
- Reset asserted mid-run forces all reset values immediately (asynchronous).

## Structure
- Package `game_timer_pkg` holds:
  - state enum: IDLE, RUN, PAUSE, DONE;
  - constant BCD_MAX = 4'd9;
  - digit clamp function.
- Sub-module `bcd_updown_counter`:
  - parameter DIGITS;
  - inputs: en, dir, load, load_val;
  - outputs: q, at_max (all 9s), at_zero;
  - per-digit carry/borrow chain.
- Top module contains the FSM, prescaler, expired register and display outputs.

## Test plan
All scenarios use TICK_CNT_MAX=3, DIGITS=3, FRAC_DIGITS=1.
- Reset then up-count:
  - check `seg_en`=1 after the first edge and `point`=3'b010;
  - start with `mode`=0 → `data`=0x001 at edge 4, 0x010 at edge 40.
- Up saturation:
  - load 0x998, start up → 0x999 at edge 4, `expired` high for 1 cycle, `running`=0;
  - a further start leaves `data` at 0x999.
- Countdown:
  - load 0x012, start with `mode`=1 → 0x011, 0x010, 0x009 (borrow), …, 0x000 at edge 48;
  - `expired` pulses once; `mode` toggled mid-run has no effect.
- Pause/resume:
  - start, pause when prescaler=2 (edge 6), hold 10 cycles → `data` stays 0x001;
  - resume → 0x002 on the 2nd edge after resume.
- Priority:
  - clear+start together in RUN → `data`=0, IDLE, `running`=0;
  - load during RUN is ignored;
  - load 0x0A5 in IDLE → `data`=0x095.
- Zero countdown: load 0, start with `mode`=1 → DONE and `expired` pulse on the next cycle, `data`=0.

Source files
------------

// File: rtl/game_timer_pkg.sv
// game_timer_pkg: shared definitions for the BCD game timer.
//   state_e   : timer FSM states (IDLE, RUN, PAUSE, DONE)
//   BCD_MAX   : largest legal BCD digit value
//   bcd_clamp : limits a 4-bit digit to the BCD range 0..9
package game_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [3:0] BCD_MAX = 4'd9;

   // Digits above 9 are not valid BCD; saturate them to 9.
   function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
      logic [3:0] res;
      if (digit > BCD_MAX) begin
         res = BCD_MAX;
      end else begin
         res = digit;
      end
      return res;
   endfunction

endpackage

// File: rtl/game_timer_gen_bcd_updown_counter.sv
// bcd_updown_counter: DIGITS-wide packed BCD up/down counter.
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   clr                : synchronous clear to zero (highest priority)
//   load, load_val     : synchronous load, each digit clamped to 9
//   en, dir            : one count step when en=1; dir 0 = up, 1 = down
//   q                  : registered count, digit 0 least significant
//   at_max, at_zero    : q is all 9s / q is all 0s
// The counter saturates: a step past all-9s (up) or zero (down) is dropped.
module bcd_updown_counter
   import game_timer_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  clr,
   input  logic                  en,
   input  logic                  dir,
   input  logic                  load,
   input  logic [DIGITS*4-1:0]   load_val,
   output logic [DIGITS*4-1:0]   q,
   output logic                  at_max,
   output logic                  at_zero
);

   logic [DIGITS*4-1:0] q_r;
   logic [DIGITS*4-1:0] q_nxt_s;
   logic [DIGITS*4-1:0] load_clamped_s;
   logic [3:0]          digit_s;
   logic                chain_s;
   logic                sat_s;

   assign at_max  = (q_r == {DIGITS{BCD_MAX}});
   assign at_zero = (q_r == {(DIGITS*4){1'b0}});
   assign q       = q_r;

   // Block a step that would wrap past the terminal value in the current direction.
   always_comb begin
      if (dir) begin
         sat_s = at_zero;
      end else begin
         sat_s = at_max;
      end
   end

   // Per-digit preset clamp.
   always_comb begin
      load_clamped_s = {(DIGITS*4){1'b0}};
      for (int i = 0; i < DIGITS; i++) begin
         load_clamped_s[i*4 +: 4] = bcd_clamp(load_val[i*4 +: 4]);
      end
   end

   // Ripple carry (up) / borrow (down) chain, seeded with 1 at digit 0.
   always_comb begin
      q_nxt_s = q_r;
      chain_s = 1'b1;
      digit_s = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         digit_s = q_r[i*4 +: 4];
         if (chain_s) begin
            if (!dir) begin
               if (digit_s == BCD_MAX) begin
                  q_nxt_s[i*4 +: 4] = 4'd0;
                  chain_s           = 1'b1;
               end else begin
                  q_nxt_s[i*4 +: 4] = digit_s + 4'd1;
                  chain_s           = 1'b0;
               end
            end else begin
               if (digit_s == 4'd0) begin
                  q_nxt_s[i*4 +: 4] = BCD_MAX;
                  chain_s           = 1'b1;
               end else begin
                  q_nxt_s[i*4 +: 4] = digit_s - 4'd1;
                  chain_s           = 1'b0;
               end
            end
         end else begin
            q_nxt_s[i*4 +: 4] = digit_s;
         end
      end
   end

   // Count register: clear > load > step.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         q_r <= {(DIGITS*4){1'b0}};
      end else if (clr) begin
         q_r <= {(DIGITS*4){1'b0}};
      end else if (load) begin
         q_r <= load_clamped_s;
      end else if (en && !sat_s) begin
         q_r <= q_nxt_s;
      end else begin
         q_r <= q_r;
      end
   end

endmodule

// File: rtl/game_timer_gen.sv
// game_timer_gen: BCD stopwatch / countdown timer feeding the 7-segment driver.
// Parameters: TICK_CNT_MAX (prescaler terminal, tick = TICK_CNT_MAX+1 clocks),
//             DIGITS (2..6), FRAC_DIGITS (0..DIGITS-1).
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   clear_signal       : synchronous clear (count 0, IDLE)
//   start_signal       : start from IDLE / resume from PAUSE
//   pause_signal       : pause while running
//   mode               : 0 up, 1 down; captured when starting from IDLE
//   load_en, load_val  : BCD preset (ignored while running)
//   data               : packed BCD count
//   point, sign        : constant decimal-point mask / sign (0)
//   seg_en             : display enable, high from the first edge after reset
//   running            : high while in RUN
//   expired            : one-cycle pulse when the terminal count is reached
module game_timer_gen
   import game_timer_pkg::*;
#(
   parameter int TICK_CNT_MAX = 2_499_999,
   parameter int DIGITS       = 4,
   parameter int FRAC_DIGITS  = 1
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  clear_signal,
   input  logic                  start_signal,
   input  logic                  pause_signal,
   input  logic                  mode,
   input  logic                  load_en,
   input  logic [DIGITS*4-1:0]   load_val,
   output logic [DIGITS*4-1:0]   data,
   output logic [DIGITS-1:0]     point,
   output logic                  sign,
   output logic                  seg_en,
   output logic                  running,
   output logic                  expired
);

   localparam logic [1:0] S_IDLE  = ST_IDLE;
   localparam logic [1:0] S_RUN   = ST_RUN;
   localparam logic [1:0] S_PAUSE = ST_PAUSE;
   localparam logic [1:0] S_DONE  = ST_DONE;

   localparam int             PW        = (TICK_CNT_MAX > 0) ? $clog2(TICK_CNT_MAX + 1) : 1;
   localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_CNT_MAX);
   localparam logic [PW-1:0]  PRESC_ONE = PW'(1);
   localparam logic [PW-1:0]  PRESC_ZERO = PW'(0);

   // Count values one step before the terminal value in each direction.
   localparam logic [DIGITS*4-1:0] CNT_ONE      = {{(DIGITS-1){4'd0}}, 4'd1};
   localparam logic [DIGITS*4-1:0] CNT_NEAR_MAX = {{(DIGITS-1){BCD_MAX}}, 4'd8};

   logic [1:0]           state_r,   state_nxt_s;
   logic [PW-1:0]        presc_r,   presc_nxt_s;
   logic                 mode_q_r,  mode_nxt_s;
   logic                 expired_r, expired_nxt_s;
   logic                 running_r;
   logic                 seg_en_r;
   logic                 tick_s;
   logic                 load_s;
   logic                 term_s;
   logic [DIGITS*4-1:0]  cnt_q_s;
   logic                 cnt_max_s;
   logic                 cnt_zero_s;

   bcd_updown_counter #(
      .DIGITS (DIGITS)
   ) u_cnt (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .clr       (clear_signal),
      .en        (tick_s),
      .dir       (mode_q_r),
      .load      (load_s),
      .load_val  (load_val),
      .q         (cnt_q_s),
      .at_max    (cnt_max_s),
      .at_zero   (cnt_zero_s)
   );

   // The upcoming tick lands on (or is already at) the terminal value.
   always_comb begin
      if (mode_q_r) begin
         term_s = cnt_zero_s | (cnt_q_s == CNT_ONE);
      end else begin
         term_s = cnt_max_s | (cnt_q_s == CNT_NEAR_MAX);
      end
   end

   // FSM and prescaler next state; clear > load > start/pause.
   always_comb begin
      state_nxt_s   = state_r;
      presc_nxt_s   = presc_r;
      mode_nxt_s    = mode_q_r;
      expired_nxt_s = 1'b0;
      tick_s        = 1'b0;
      load_s        = 1'b0;
      if (clear_signal) begin
         state_nxt_s = S_IDLE;
         presc_nxt_s = PRESC_ZERO;
      end else if (load_en && (state_r != S_RUN)) begin
         load_s      = 1'b1;
         state_nxt_s = S_IDLE;
         presc_nxt_s = PRESC_ZERO;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start_signal) begin
                  mode_nxt_s  = mode;
                  presc_nxt_s = PRESC_ZERO;
                  // Counting down from zero expires immediately.
                  if (mode && cnt_zero_s) begin
                     state_nxt_s   = S_DONE;
                     expired_nxt_s = 1'b1;
                  end else begin
                     state_nxt_s = S_RUN;
                  end
               end else begin
                  state_nxt_s = S_IDLE;
               end
            end
            S_RUN: begin
               if (pause_signal) begin
                  state_nxt_s = S_PAUSE;
               end else if (presc_r == PRESC_MAX) begin
                  presc_nxt_s = PRESC_ZERO;
                  tick_s      = 1'b1;
                  if (term_s) begin
                     state_nxt_s   = S_DONE;
                     expired_nxt_s = 1'b1;
                  end else begin
                     state_nxt_s = S_RUN;
                  end
               end else begin
                  presc_nxt_s = presc_r + PRESC_ONE;
               end
            end
            S_PAUSE: begin
               if (start_signal) begin
                  state_nxt_s = S_RUN;
               end else begin
                  state_nxt_s = S_PAUSE;
               end
            end
            S_DONE: begin
               state_nxt_s = S_DONE;
            end
            default: begin
               state_nxt_s = S_IDLE;
               presc_nxt_s = PRESC_ZERO;
            end
         endcase
      end
   end

   // Control and status registers.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_r   <= S_IDLE;
         presc_r   <= PRESC_ZERO;
         mode_q_r  <= 1'b0;
         expired_r <= 1'b0;
         running_r <= 1'b0;
         seg_en_r  <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         presc_r   <= presc_nxt_s;
         mode_q_r  <= mode_nxt_s;
         expired_r <= expired_nxt_s;
         running_r <= (state_nxt_s == S_RUN);
         seg_en_r  <= 1'b1;
      end
   end

   assign data    = cnt_q_s;
   assign expired = expired_r;
   assign running = running_r;
   assign seg_en  = seg_en_r;
   assign sign    = 1'b0;
   assign point   = (FRAC_DIGITS > 0) ? ({{(DIGITS-1){1'b0}}, 1'b1} << FRAC_DIGITS)
                                      : {DIGITS{1'b0}};

endmodule

// File: tb/tb_game_timer_gen.sv
// tb_game_timer_gen: directed scenarios plus randomized traffic for
// game_timer_gen, checked against an integer-valued reference model.
module tb_game_timer_gen;

   localparam int TMAX = 3;
   localparam int DIG  = 3;
   localparam int FRAC = 1;
   localparam int MAXV = 999;
   localparam int P_IDLE = 0, P_RUN = 1, P_PAUSE = 2, P_DONE = 3;

   logic            sys_clk = 1'b0;
   logic            sys_rst_n = 1'b0;
   logic            clear_signal = 1'b0;
   logic            start_signal = 1'b0;
   logic            pause_signal = 1'b0;
   logic            mode = 1'b0;
   logic            load_en = 1'b0;
   logic [DIG*4-1:0] load_val = '0;
   logic [DIG*4-1:0] data;
   logic [DIG-1:0]   point;
   logic            sign, seg_en, running, expired;

   int checks = 0;
   int failures = 0;

   int m_val, m_phase, m_presc;
   bit m_mode, m_exp, m_run, m_seg;

   game_timer_gen #(.TICK_CNT_MAX(TMAX), .DIGITS(DIG), .FRAC_DIGITS(FRAC)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clear_signal(clear_signal),
      .start_signal(start_signal), .pause_signal(pause_signal), .mode(mode),
      .load_en(load_en), .load_val(load_val), .data(data), .point(point),
      .sign(sign), .seg_en(seg_en), .running(running), .expired(expired));

   always #5 sys_clk = ~sys_clk;

   function automatic logic [DIG*4-1:0] to_bcd(input int v);
      logic [DIG*4-1:0] b;
      int r;
      b = '0;
      r = v;
      for (int i = 0; i < DIG; i++) begin
         b[i*4 +: 4] = 4'(r % 10);
         r = r / 10;
      end
      return b;
   endfunction

   function automatic int clamp_val(input logic [DIG*4-1:0] lv);
      int v, mult, d;
      v = 0;
      mult = 1;
      for (int i = 0; i < DIG; i++) begin
         d = int'(lv[i*4 +: 4]);
         if (d > 9) d = 9;
         v = v + d * mult;
         mult = mult * 10;
      end
      return v;
   endfunction

   task automatic model_reset();
      m_val = 0; m_phase = P_IDLE; m_presc = 0;
      m_mode = 0; m_exp = 0; m_run = 0; m_seg = 0;
   endtask

   // One clock edge of the timer as described by its operating rules.
   task automatic model_edge();
      if (!sys_rst_n) return;
      m_seg = 1;
      m_exp = 0;
      if (clear_signal) begin
         m_val = 0; m_presc = 0; m_phase = P_IDLE;
      end else if (load_en && m_phase != P_RUN) begin
         m_val = clamp_val(load_val); m_presc = 0; m_phase = P_IDLE;
      end else begin
         case (m_phase)
            P_IDLE: if (start_signal) begin
               m_mode = mode;
               m_presc = 0;
               if (mode && m_val == 0) begin m_phase = P_DONE; m_exp = 1; end
               else m_phase = P_RUN;
            end
            P_RUN: if (pause_signal) m_phase = P_PAUSE;
               else if (m_presc == TMAX) begin
                  m_presc = 0;
                  if (m_mode) begin
                     if (m_val > 0) m_val = m_val - 1;
                     if (m_val == 0) begin m_phase = P_DONE; m_exp = 1; end
                  end else begin
                     if (m_val < MAXV) m_val = m_val + 1;
                     if (m_val == MAXV) begin m_phase = P_DONE; m_exp = 1; end
                  end
               end else m_presc = m_presc + 1;
            P_PAUSE: if (start_signal) m_phase = P_RUN;
            default: ;
         endcase
      end
      m_run = (m_phase == P_RUN);
   endtask

   task automatic step();
      @(posedge sys_clk);
      model_edge();
      #1;
   endtask

   task automatic pulse_clear();
      clear_signal = 1'b1; step(); clear_signal = 1'b0;
   endtask

   task automatic do_load(input logic [DIG*4-1:0] v);
      load_en = 1'b1; load_val = v; step(); load_en = 1'b0;
   endtask

   task automatic do_start(input logic m);
      start_signal = 1'b1; mode = m; step(); start_signal = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++; if (data !== 12'h000) begin failures++; $display("FAIL reset_data got=%h exp=%h", data, 12'h000); end
      checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", running); end
      checks++; if (expired !== 1'b0) begin failures++; $display("FAIL reset_expired got=%b exp=0", expired); end
      checks++; if (seg_en !== 1'b0) begin failures++; $display("FAIL reset_seg_en got=%b exp=0", seg_en); end
      checks++; if (sign !== 1'b0) begin failures++; $display("FAIL reset_sign got=%b exp=0", sign); end
      checks++; if (point !== 3'b010) begin failures++; $display("FAIL reset_point got=%b exp=010", point); end
      @(posedge sys_clk); #1;
      sys_rst_n = 1'b1;
      model_reset();
      step();
      checks++; if (seg_en !== 1'b1) begin failures++; $display("FAIL seg_en_first_edge got=%b exp=1", seg_en); end
   endtask

   task automatic test_up_count();
      do_start(1'b0);
      for (int e = 1; e <= 40; e++) begin
         step();
         checks++; if (data !== to_bcd(m_val)) begin failures++; $display("FAIL up_data edge=%0d got=%h exp=%h", e, data, to_bcd(m_val)); end
         if (e == 4) begin
            checks++; if (data !== 12'h001) begin failures++; $display("FAIL up_first_tick got=%h exp=001", data); end
            checks++; if (running !== 1'b1) begin failures++; $display("FAIL up_running got=%b exp=1", running); end
         end
         if (e == 40) begin
            checks++; if (data !== 12'h010) begin failures++; $display("FAIL up_edge40 got=%h exp=010", data); end
         end
      end
      pulse_clear();
   endtask

   task automatic test_up_saturation();
      do_load(12'h998);
      do_start(1'b0);
      repeat (4) step();
      checks++; if (data !== 12'h999) begin failures++; $display("FAIL sat_data got=%h exp=999", data); end
      checks++; if (expired !== 1'b1) begin failures++; $display("FAIL sat_expired got=%b exp=1", expired); end
      checks++; if (running !== 1'b0) begin failures++; $display("FAIL sat_running got=%b exp=0", running); end
      step();
      checks++; if (expired !== 1'b0) begin failures++; $display("FAIL sat_expired_width got=%b exp=0", expired); end
      start_signal = 1'b1;
      repeat (6) step();
      start_signal = 1'b0;
      checks++; if (data !== 12'h999) begin failures++; $display("FAIL sat_hold got=%h exp=999", data); end
      checks++; if (running !== 1'b0) begin failures++; $display("FAIL sat_done_running got=%b exp=0", running); end
      pulse_clear();
   endtask

   task automatic test_countdown();
      int pulses;
      pulses = 0;
      do_load(12'h012);
      do_start(1'b1);
      for (int e = 1; e <= 50; e++) begin
         mode = 1'($urandom);
         step();
         if (expired === 1'b1) pulses++;
         checks++; if (data !== to_bcd(m_val)) begin failures++; $display("FAIL down_data edge=%0d got=%h exp=%h", e, data, to_bcd(m_val)); end
         if (e == 12) begin
            checks++; if (data !== 12'h009) begin failures++; $display("FAIL down_borrow got=%h exp=009", data); end
         end
         if (e == 47) begin
            checks++; if (data !== 12'h001) begin failures++; $display("FAIL down_edge47 got=%h exp=001", data); end
         end
         if (e == 48) begin
            checks++; if (data !== 12'h000 || expired !== 1'b1) begin failures++; $display("FAIL down_edge48 got=%h/%b exp=000/1", data, expired); end
         end
      end
      checks++; if (pulses != 1) begin failures++; $display("FAIL down_pulses got=%0d exp=1", pulses); end
      mode = 1'b0;
      pulse_clear();
   endtask

   task automatic test_pause_resume();
      do_start(1'b0);
      repeat (6) step();
      pause_signal = 1'b1; step(); pause_signal = 1'b0;
      checks++; if (running !== 1'b0) begin failures++; $display("FAIL pause_running got=%b exp=0", running); end
      for (int c = 0; c < 10; c++) begin
         step();
         checks++; if (data !== 12'h001) begin failures++; $display("FAIL pause_hold cyc=%0d got=%h exp=001", c, data); end
      end
      do_start(1'b1);
      checks++; if (data !== 12'h001 || running !== 1'b1) begin failures++; $display("FAIL resume_edge got=%h/%b exp=001/1", data, running); end
      step();
      checks++; if (data !== 12'h001) begin failures++; $display("FAIL resume_plus1 got=%h exp=001", data); end
      step();
      checks++; if (data !== 12'h002) begin failures++; $display("FAIL resume_plus2 got=%h exp=002", data); end
      pulse_clear();
   endtask

   task automatic test_priority();
      do_start(1'b0);
      repeat (2) step();
      clear_signal = 1'b1; start_signal = 1'b1; step();
      clear_signal = 1'b0; start_signal = 1'b0;
      checks++; if (data !== 12'h000 || running !== 1'b0) begin failures++; $display("FAIL clear_start got=%h/%b exp=000/0", data, running); end
      do_start(1'b0);
      repeat (5) step();
      do_load(12'h555);
      checks++; if (data !== 12'h001 || running !== 1'b1) begin failures++; $display("FAIL load_in_run got=%h/%b exp=001/1", data, running); end
      pulse_clear();
      do_load(12'h0A5);
      checks++; if (data !== 12'h095) begin failures++; $display("FAIL load_clamp got=%h exp=095", data); end
      pulse_clear();
   endtask

   task automatic test_zero_countdown();
      do_load(12'h000);
      do_start(1'b1);
      checks++; if (expired !== 1'b1 || data !== 12'h000 || running !== 1'b0) begin failures++; $display("FAIL zero_down got=%b/%h/%b exp=1/000/0", expired, data, running); end
      step();
      checks++; if (expired !== 1'b0) begin failures++; $display("FAIL zero_down_width got=%b exp=0", expired); end
      pulse_clear();
   endtask

   task automatic test_async_reset();
      do_start(1'b0);
      repeat (6) step();
      #2;
      sys_rst_n = 1'b0;
      #1;
      model_reset();
      checks++; if (data !== 12'h000 || running !== 1'b0 || seg_en !== 1'b0) begin failures++; $display("FAIL async_reset got=%h/%b/%b exp=000/0/0", data, running, seg_en); end
      @(posedge sys_clk); #1;
      sys_rst_n = 1'b1;
      step();
      checks++; if (seg_en !== 1'b1 || data !== 12'h000) begin failures++; $display("FAIL reset_release got=%b/%h exp=1/000", seg_en, data); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 800; c++) begin
         clear_signal = ($urandom_range(0, 59) == 0);
         load_en      = ($urandom_range(0, 24) == 0);
         load_val     = ($urandom_range(0, 1) == 1) ? 12'($urandom) : {8'h00, 4'($urandom_range(0, 6))};
         start_signal = ($urandom_range(0, 5) == 0);
         pause_signal = ($urandom_range(0, 9) == 0);
         mode         = 1'($urandom);
         step();
         checks++;
         if (data !== to_bcd(m_val) || running !== m_run || expired !== m_exp || seg_en !== m_seg) begin
            failures++;
            $display("FAIL random cyc=%0d got=%h/%b/%b/%b exp=%h/%b/%b/%b", c, data, running, expired, seg_en,
                     to_bcd(m_val), m_run, m_exp, m_seg);
         end
      end
      clear_signal = 1'b0; load_en = 1'b0; start_signal = 1'b0; pause_signal = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_up_count();
      test_up_saturation();
      test_countdown();
      test_pause_resume();
      test_priority();
      test_zero_countdown();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
